// File: rtl/nbcac_20di_encoder_seq_if.sv
// Handshake bundle between the NBCAC 20-bit encoder and its producer/consumer.
// master = the side that supplies words and accepts codewords; slave = the encoder.
interface nbcac_20di_encoder_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] v;
    logic        out_valid;
    logic        out_ready;
    logic [29:1] d;
    logic        chk_err;

    modport master (
        output in_valid, v, out_ready,
        input  in_ready, out_valid, d, chk_err
    );

    modport slave (
        input  in_valid, v, out_ready,
        output in_ready, out_valid, d, chk_err
    );
endinterface

// File: rtl/nbcac_20di_encoder_seq.sv
// Greedy one-weight-per-cycle NBCAC encoder: 20-bit word -> 29-bit codeword d[29:1].
// Optional self-check (weighted re-sum vs. accepted word) enabled by macro NBCAC_ENC_SELFCHECK_EN.
module nbcac_20di_encoder_seq (
    input  logic                       clk,
    input  logic                       rst,
    nbcac_20di_encoder_seq_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [20:0] rem_q, rem_d;
    logic [4:0]  idx_q, idx_d;
    logic [29:1] d_q, d_d;

    logic [20:0] w_cur;
    logic        take;
    logic [20:0] rem_after;
    logic [29:1] d_calc;

    function automatic logic [20:0] weight_of(input logic [4:0] k);
        logic [20:0] w;
        case (k)
            5'd1:  w = 21'd1;
            5'd2:  w = 21'd635622;
            5'd3:  w = 21'd392836;
            5'd4:  w = 21'd242786;
            5'd5:  w = 21'd150050;
            5'd6:  w = 21'd92736;
            5'd7:  w = 21'd57314;
            5'd8:  w = 21'd35422;
            5'd9:  w = 21'd21892;
            5'd10: w = 21'd13530;
            5'd11: w = 21'd8362;
            5'd12: w = 21'd5168;
            5'd13: w = 21'd3194;
            5'd14: w = 21'd1974;
            5'd15: w = 21'd1220;
            5'd16: w = 21'd754;
            5'd17: w = 21'd466;
            5'd18: w = 21'd288;
            5'd19: w = 21'd178;
            5'd20: w = 21'd110;
            5'd21: w = 21'd68;
            5'd22: w = 21'd42;
            5'd23: w = 21'd26;
            5'd24: w = 21'd16;
            5'd25: w = 21'd10;
            5'd26: w = 21'd6;
            5'd27: w = 21'd4;
            5'd28: w = 21'd2;
            5'd29: w = 21'd2;
            default: w = 21'd0;
        endcase
        return w;
    endfunction

    assign w_cur     = weight_of(idx_q);
    assign take      = (rem_q >= w_cur);
    assign rem_after = take ? (rem_q - w_cur) : rem_q;

    // Only the bit selected by idx changes; d[1] picks up the leftover remainder bit on the last step.
    generate
        for (genvar gi = 2; gi <= 29; gi++) begin : g_dbit
            assign d_calc[gi] = (idx_q == 5'(gi)) ? take : d_q[gi];
        end
    endgenerate
    assign d_calc[1] = (idx_q == 5'd29) ? rem_after[0] : d_q[1];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        d_d     = d_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    rem_d   = {1'b0, bus.v};
                    idx_d   = 5'd2;
                    d_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d = rem_after;
                d_d   = d_calc;
                if (idx_q == 5'd29) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            idx_q   <= 5'd2;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            d_q     <= d_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.d         = d_q;

`ifdef NBCAC_ENC_SELFCHECK_EN
    logic [19:0] shadow_q, shadow_d;
    logic        chk_err_q, chk_err_d;
    logic [21:0] term [1:29];
    logic [21:0] wsum;

    generate
        for (genvar gi = 1; gi <= 29; gi++) begin : g_term
            assign term[gi] = d_q[gi] ? {1'b0, weight_of(5'(gi))} : 22'd0;
        end
    endgenerate

    always_comb begin
        wsum = '0;
        for (int k = 1; k <= 29; k++) begin
            wsum = wsum + term[k];
        end
    end

    always_comb begin
        shadow_d  = shadow_q;
        chk_err_d = chk_err_q;
        if (state_q == IDLE && bus.in_valid) begin
            shadow_d = bus.v;
        end
        if (state_q == DONE && wsum != {2'b00, shadow_q}) begin
            chk_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= '0;
            chk_err_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign bus.chk_err = chk_err_q;
`else
    assign bus.chk_err = 1'b0;
`endif
endmodule
